// File: rtl/elc3_mem_pkg.sv
// Shared types and constants for the eLC-3 SRAM memory path.
package elc3_mem_pkg;

  localparam int unsigned SRAM_AW = 20;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } sram_state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_LDR
  } grant_t;

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational two-way round-robin picker between the CPU and loader ports.
module sram_rr_pick
  import elc3_mem_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  grant_t last_i,
  output grant_t gnt_o,
  output logic   valid_o
);

  // On a tie the port that did not win most recently gets the grant.
  always_comb begin
    valid_o = cpu_req_i | ldr_req_i;
    gnt_o   = GNT_CPU;
    if (cpu_req_i && ldr_req_i) begin
      gnt_o = (last_i == GNT_CPU) ? GNT_LDR : GNT_CPU;
    end else if (ldr_req_i) begin
      gnt_o = GNT_LDR;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU port and the loader/debug port.
// Every access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE; all pins registered.
module sram_arbiter
  import elc3_mem_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Cpu_Req,
  input  logic               Cpu_Wr,
  input  logic [15:0]        Cpu_Addr,
  input  logic [15:0]        Cpu_Wdata,
  output logic [15:0]        Cpu_Rdata,
  output logic               Cpu_Ready,
  input  logic               Ldr_Req,
  input  logic               Ldr_Wr,
  input  logic [SRAM_AW-1:0] Ldr_Addr,
  input  logic [15:0]        Ldr_Wdata,
  output logic [15:0]        Ldr_Rdata,
  output logic               Ldr_Ready,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        Dq_Out,
  output logic               Dq_Oe,
  input  logic [15:0]        Dq_In
);

  localparam int unsigned CntW = 4;

  sram_state_t        state_q;
  grant_t             last_gnt_q;   // also identifies the port owning the current access
  logic               wr_q;
  logic [CntW-1:0]    cnt_q;
  logic [15:0]        cpu_rdata_q, ldr_rdata_q;
  logic               cpu_ready_q, ldr_ready_q;
  logic               ce_n_q, oe_n_q, we_n_q, bl_n_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [15:0]        dq_out_q;
  logic               dq_oe_q;

  grant_t             pick_gnt;
  logic               pick_valid;
  logic               sel_wr;
  logic [SRAM_AW-1:0] sel_addr;
  logic [15:0]        sel_wdata;

  sram_rr_pick u_pick (
    .cpu_req_i (Cpu_Req),
    .ldr_req_i (Ldr_Req),
    .last_i    (last_gnt_q),
    .gnt_o     (pick_gnt),
    .valid_o   (pick_valid)
  );

  // Present the winning port's command so IDLE can latch it in one step.
  always_comb begin
    if (pick_gnt == GNT_LDR) begin
      sel_wr    = Ldr_Wr;
      sel_addr  = Ldr_Addr;
      sel_wdata = Ldr_Wdata;
    end else begin
      sel_wr    = Cpu_Wr;
      sel_addr  = SRAM_AW'(Cpu_Addr);
      sel_wdata = Cpu_Wdata;
    end
  end

  // Access sequencer: pin values are set on the edge entering each state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= GNT_LDR;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      ldr_ready_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bl_n_q      <= 1'b1;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      ldr_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q    <= SETUP;
            last_gnt_q <= pick_gnt;
            wr_q       <= sel_wr;
            ce_n_q     <= 1'b0;
            bl_n_q     <= 1'b0;
            addr_q     <= sel_addr;
            oe_n_q     <= sel_wr;
            dq_oe_q    <= sel_wr;
            dq_out_q   <= sel_wr ? sel_wdata : '0;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= CntW'(ACCESS_CYCLES - 1);
          we_n_q  <= ~wr_q;
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            if (last_gnt_q == GNT_CPU) begin
              cpu_ready_q <= 1'b1;
              if (!wr_q) cpu_rdata_q <= Dq_In;
            end else begin
              ldr_ready_q <= 1'b1;
              if (!wr_q) ldr_rdata_q <= Dq_In;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          ce_n_q   <= 1'b1;
          oe_n_q   <= 1'b1;
          we_n_q   <= 1'b1;
          bl_n_q   <= 1'b1;
          addr_q   <= '0;
          dq_out_q <= '0;
          dq_oe_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Cpu_Rdata = cpu_rdata_q;
  assign Cpu_Ready = cpu_ready_q;
  assign Ldr_Rdata = ldr_rdata_q;
  assign Ldr_Ready = ldr_ready_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_LB_N = bl_n_q;
  assign SRAM_UB_N = bl_n_q;
  assign SRAM_ADDR = addr_q;
  assign Dq_Out    = dq_out_q;
  assign Dq_Oe     = dq_oe_q;

endmodule
